// File: rtl/tdm_demux4.sv
`timescale 1ns/1ps
// Receive end of a 4:1 slot-multiplexed link. Collects slots 0..3 into
// shadow registers and publishes all four channels together when a frame completes.
module tdm_demux4 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              frame_sync,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] dout2,
  output logic [DATA_W-1:0] dout3,
  output logic              dout_valid,
  output logic [1:0]        slot,
  output logic              locked,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned SLOT_W = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DATA_W-1:0] shadow0_q, shadow0_d;
  logic [DATA_W-1:0] shadow1_q, shadow1_d;
  logic [DATA_W-1:0] shadow2_q, shadow2_d;
  logic [DATA_W-1:0] dout0_q, dout0_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;
  logic [DATA_W-1:0] dout2_q, dout2_d;
  logic [DATA_W-1:0] dout3_q, dout3_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: sync acquires lock, a slot-0 beat without sync drops it
  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (frame_sync) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!frame_sync && (slot_q == SLOT_W'(0))) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and flag next values
  always_comb begin
    slot_d       = slot_q;
    shadow0_d    = shadow0_q;
    shadow1_d    = shadow1_q;
    shadow2_d    = shadow2_q;
    dout0_d      = dout0_q;
    dout1_d      = dout1_q;
    dout2_d      = dout2_q;
    dout3_d      = dout3_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          if (frame_sync) begin
            shadow0_d = din;
            slot_d    = SLOT_W'(1);
          end
        end
        RUN: begin
          if (frame_sync) begin
            // A sync anywhere but slot 0 restarts the frame from this beat
            frame_err_d = (slot_q != SLOT_W'(0));
            shadow0_d   = din;
            slot_d      = SLOT_W'(1);
          end else begin
            unique case (slot_q)
              SLOT_W'(0): begin
                frame_err_d = 1'b1;
                slot_d      = SLOT_W'(0);
              end
              SLOT_W'(1): begin
                shadow1_d = din;
                slot_d    = SLOT_W'(2);
              end
              SLOT_W'(2): begin
                shadow2_d = din;
                slot_d    = SLOT_W'(3);
              end
              default: begin
                dout0_d      = shadow0_q;
                dout1_d      = shadow1_q;
                dout2_d      = shadow2_q;
                dout3_d      = din;
                dout_valid_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + CNT_W'(1);
                slot_d       = SLOT_W'(0);
              end
            endcase
          end
        end
        default: begin
          slot_d = SLOT_W'(0);
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q       <= '0;
      shadow0_q    <= '0;
      shadow1_q    <= '0;
      shadow2_q    <= '0;
      dout0_q      <= '0;
      dout1_q      <= '0;
      dout2_q      <= '0;
      dout3_q      <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      slot_q       <= slot_d;
      shadow0_q    <= shadow0_d;
      shadow1_q    <= shadow1_d;
      shadow2_q    <= shadow2_d;
      dout0_q      <= dout0_d;
      dout1_q      <= dout1_d;
      dout2_q      <= dout2_d;
      dout3_q      <= dout3_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign dout0      = dout0_q;
  assign dout1      = dout1_q;
  assign dout2      = dout2_q;
  assign dout3      = dout3_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = (state_q == RUN);
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
`timescale 1ns/1ps
// Randomized and directed bench for tdm_demux4: a frame-level reference model
// queues expected frame/error events; a monitor pops them when the DUT pulses.
module tb_tdm_demux4;

  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              din_valid;
  logic              frame_sync;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout0, dout1, dout2, dout3;
  logic              dout_valid;
  logic [1:0]        slot;
  logic              locked;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  tdm_demux4 #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .frame_sync(frame_sync),
    .din(din), .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .dout_valid(dout_valid), .slot(slot), .locked(locked),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
    logic [7:0]  cnt;
  } ev_t;

  ev_t ev_q[$];

  // Reference model state: what the DUT should show after the pending edge
  bit         m_locked;
  int         m_slot;
  logic [7:0] m_part [4];
  logic [7:0] m_out  [4];
  int         m_cnt;
  bit         m_valid, m_err;

  int n_vec  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic v, input logic s, input logic [7:0] d);
    ev_t ev;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!r) begin
      m_locked = 1'b0;
      m_slot   = 0;
      m_cnt    = 0;
      for (int i = 0; i < 4; i++) begin
        m_part[i] = '0;
        m_out[i]  = '0;
      end
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_part[0] = d;
          m_slot    = 1;
          m_locked  = 1'b1;
        end
      end else if (s) begin
        m_err     = (m_slot != 0);
        m_part[0] = d;
        m_slot    = 1;
      end else if (m_slot == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_part[m_slot] = d;
        if (m_slot == 3) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_part[i];
          m_cnt   = (m_cnt + 1) % 256;
          m_valid = 1'b1;
          m_slot  = 0;
        end else begin
          m_slot = m_slot + 1;
        end
      end
    end
    if (m_valid || m_err) begin
      ev.is_err = m_err;
      ev.data   = {m_out[3], m_out[2], m_out[1], m_out[0]};
      ev.cnt    = 8'(m_cnt);
      ev_q.push_back(ev);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    rst_n      = r;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    model_step(r, v, s, d);
  endtask

  task automatic beat(input logic s, input logic [7:0] d);
    drive(1'b1, 1'b1, s, d);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    beat(1'b1, a); beat(1'b0, b); beat(1'b0, c); beat(1'b0, e);
  endtask

  // Event monitor: pop an expected event whenever the DUT pulses
  initial begin
    ev_t exp_ev;
    forever begin
      @(posedge clk);
      #1;
      if (dout_valid || frame_err) begin
        n_vec++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL event: unexpected pulse valid=%0b err=%0b (no event expected)", dout_valid, frame_err);
        end else begin
          exp_ev = ev_q.pop_front();
          if (dout_valid !== !exp_ev.is_err || frame_err !== exp_ev.is_err ||
              {dout3, dout2, dout1, dout0} !== exp_ev.data || frame_cnt !== exp_ev.cnt) begin
            n_fail++;
            $display("FAIL event: got valid=%0b err=%0b dout=%h cnt=%0d, expected err=%0b dout=%h cnt=%0d",
                     dout_valid, frame_err, {dout3, dout2, dout1, dout0}, frame_cnt,
                     exp_ev.is_err, exp_ev.data, exp_ev.cnt);
          end
        end
      end
    end
  end

  // Status monitor: registered outputs every cycle against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n_vec++;
      if (slot !== 2'(m_slot) || locked !== m_locked || frame_cnt !== 8'(m_cnt) ||
          dout_valid !== m_valid || frame_err !== m_err ||
          {dout3, dout2, dout1, dout0} !== {m_out[3], m_out[2], m_out[1], m_out[0]}) begin
        n_fail++;
        $display("FAIL status @%0t: got slot=%0d lk=%0b cnt=%0d v=%0b e=%0b dout=%h, expected slot=%0d lk=%0b cnt=%0d v=%0b e=%0b dout=%h",
                 $time, slot, locked, frame_cnt, dout_valid, frame_err, {dout3, dout2, dout1, dout0},
                 m_slot, m_locked, m_cnt, m_valid, m_err,
                 {m_out[3], m_out[2], m_out[1], m_out[0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
    model_step(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h5A);

    // Basic frame, then the same frame with gaps
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    gap(2);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    beat(1'b1, 8'h11); beat(1'b0, 8'h22); gap(3);
    beat(1'b0, 8'h33); gap(1); beat(1'b0, 8'h44);
    gap(2);

    // Unsynced beats after reset are dropped, then a good frame
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    beat(1'b0, 8'hAA); beat(1'b0, 8'hBB);
    frame(8'h01, 8'h02, 8'h03, 8'h04);

    // Early sync restarts the frame
    beat(1'b1, 8'h55); beat(1'b0, 8'h66);
    frame(8'h77, 8'h88, 8'h99, 8'hA0);
    gap(1);

    // Missing sync drops lock, then resync
    beat(1'b0, 8'h12);
    gap(1);
    frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);

    // 256 back-to-back frames wrap the counter, then reset mid-frame
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int f = 0; f < 256; f++) frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    beat(1'b1, 8'hE1); beat(1'b0, 8'hE2);
    drive(1'b0, 1'b1, 1'b0, 8'hE3);
    gap(2);

    // Random traffic, mostly well-framed with occasional violations
    for (int i = 0; i < 3000; i++) begin
      logic v, s;
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) s = 1'($urandom_range(0, 1));
      else s = (m_slot == 0);
      if ($urandom_range(0, 499) == 0) drive(1'b0, v, s, 8'($urandom));
      else drive(1'b1, v, s, 8'($urandom));
    end
    gap(3);

    n_vec++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected events never seen, required 0", ev_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- 4-channel time-division demultiplexer: the receive end of a 4:1 slot-multiplexed serial link.
- Accepts one DATA_W-bit sample per valid beat, with frame_sync marking slot 0.
- Steers each sample to its channel by slot index and publishes all four channels together once a full frame is captured.
- Sits after the link interface and feeds per-channel consumers.

Parameters:
- DATA_W, 8, width of each sample and each channel output.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- din_valid  input  1  sample beat qualifier
- frame_sync  input  1  marks current beat as slot 0; ignored when din_valid=0
- din  input  DATA_W  sample data
- dout0  output  DATA_W  channel 0 of last complete frame
- dout1  output  DATA_W  channel 1 of last complete frame
- dout2  output  DATA_W  channel 2 of last complete frame
- dout3  output  DATA_W  channel 3 of last complete frame
- dout_valid  output  1  one-cycle pulse: dout0..3 just updated
- slot  output  2  index the next accepted beat will be written to
- locked  output  1  1 while in RUN state
- frame_err  output  1  one-cycle pulse on framing violation
- frame_cnt  output  8  count of completed frames, wraps 255->0

Behaviour:
- Reset (rst_n=0 at edge):
  - dout0..3=0, dout_valid=0, slot=0, locked=0, frame_err=0, frame_cnt=0.
  - Shadow registers cleared; state=IDLE.
  - Reset mid-frame discards the partial frame; dout keeps no old data.
- States:
  - IDLE (locked=0): beats with din_valid=1, frame_sync=0 are dropped silently, no frame_err. Beat with din_valid=1, frame_sync=1: shadow0<=din, slot<=1, ->RUN.
  - RUN (locked=1): beat with din_valid=1, frame_sync=0 at slot 1..3 writes the channel for that slot.
    - Slot 1 or 2: shadow[slot]<=din, slot<=slot+1.
    - Slot 3: dout0<=shadow0, dout1<=shadow1, dout2<=shadow2, dout3<=din, all on the same edge. dout_valid=1 for exactly the following cycle. frame_cnt<=frame_cnt+1 (mod 256). slot<=0, stay RUN.
- Latency: dout/dout_valid are visible in the cycle after the slot-3 beat edge.
- Framing rules in RUN:
  - din_valid=1, frame_sync=1 at slot 0 (expected): shadow0<=din, slot<=1; no error.
  - din_valid=1, frame_sync=1 at slot 1..3 (early sync): frame_err pulse. Partial frame discarded, dout unchanged. Beat is taken as a new slot 0: shadow0<=din, slot<=1, stay RUN.
  - din_valid=1, frame_sync=0 at slot 0 (missing sync): frame_err pulse, beat dropped, slot=0, ->IDLE.
- din_valid=0: no state change, regardless of frame_sync. Gaps between beats of any length are allowed.
- dout0..3 hold between frames. They change only at frame completion or reset.
- frame_err and dout_valid are never asserted by the same beat.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then beats (sync=1, 0x11), 0x22, 0x33, 0x44 on consecutive cycles -> next cycle dout0..3=0x11/0x22/0x33/0x44, dout_valid=1 for 1 cycle, frame_cnt=1, slot=0, locked=1.
2. Same frame with din_valid=0 gaps of 0/3/1 cycles between beats -> identical outputs. dout_valid pulses only once. dout held 0 until completion.
3. Beats 0xAA, 0xBB with no sync after reset -> dropped, locked=0, no frame_err. Then a valid frame 1..4 -> dout=1,2,3,4.
4. After one good frame, send sync+0x55, 0x66, then sync+0x77, 0x88, 0x99, 0xA0 -> frame_err pulse on the 3rd beat, then dout=0x77/0x88/0x99/0xA0, frame_cnt=2.
5. After a good frame, next beat 0x12 with sync=0 -> frame_err pulse, locked=0, dout unchanged. Resync with a new frame -> recovers.
6. 256 back-to-back frames -> frame_cnt wraps to 0. Assert rst_n=0 after the 2nd beat of a frame -> all outputs 0, IDLE, no dout_valid.
